// File: rtl/alu_acc_core_if.sv
// Operation handshake and status signals between the sequencer and the
// accumulator ALU. The shared data bus stays a top-level inout of the core.
interface alu_acc_core_if #(
    parameter int WIDTH = 4
);
    logic             op_valid;
    logic             op_ready;
    logic [3:0]       op_code;
    logic [WIDTH-1:0] B;
    logic             ALU_enable;
    logic             carry_out;
    logic             acc_zero;
    logic             done;

    modport master (
        output op_valid, op_code, B, ALU_enable,
        input  op_ready, carry_out, acc_zero, done
    );

    modport slave (
        input  op_valid, op_code, B, ALU_enable,
        output op_ready, carry_out, acc_zero, done
    );
endinterface

// File: rtl/alu_acc_core.sv
// Accumulator ALU: ACC and carry registers, single-cycle ops plus a
// multi-cycle rotate-left-through-carry, result driven on a tri-state bus.
//
//  state | meaning
//  IDLE  | op_ready high, accepts one op per edge
//  ROT   | rotating one bit per cycle until the counter reaches 0
module alu_acc_core #(
    parameter int WIDTH      = 4,
    parameter bit ENABLE_DAA = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    alu_acc_core_if.slave    bus,
    inout  wire  [WIDTH-1:0] data_bus
);
    // DAA is a decimal adjust on a single BCD digit, so it only exists at 4 bits.
    localparam bit DAA_ON = ENABLE_DAA && (WIDTH == 4);
    localparam int W1     = WIDTH + 1;

    typedef enum logic {IDLE, ROT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             done_q, done_d;

    logic             accept;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_diff;
    logic [WIDTH:0]   inc_sum;
    logic [WIDTH:0]   daa_sum;

    assign accept   = bus.op_valid && (state_q == IDLE);

    // Carry/borrow come out as bit WIDTH of a WIDTH+1 wide result.
    assign add_sum  = {1'b0, acc_q} + {1'b0, bus.B} + W1'(c_q);
    assign sub_diff = {1'b0, acc_q} - {1'b0, bus.B} - W1'(c_q);
    assign inc_sum  = {1'b0, acc_q} + W1'(1);
    assign daa_sum  = {1'b0, acc_q} + W1'(6);

    // Next-state, datapath update and done pulse.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    done_d = 1'b1;
                    case (bus.op_code)
                        4'h0: {c_d, acc_d} = add_sum;
                        4'h1: begin
                            acc_d = sub_diff[WIDTH-1:0];
                            c_d   = sub_diff[WIDTH];
                        end
                        4'h2: acc_d = bus.B;
                        4'h3: {c_d, acc_d} = inc_sum;
                        4'h4: begin
                            acc_d = acc_q - WIDTH'(1);
                            c_d   = (acc_q == '0);
                        end
                        4'h5: c_d = 1'b0;
                        4'h6: c_d = 1'b1;
                        4'h7: c_d = ~c_q;
                        4'h8: {c_d, acc_d} = {acc_q, c_q};
                        4'h9: {acc_d, c_d} = {c_q, acc_q};
                        4'hA: begin
                            if (DAA_ON && ((acc_q > WIDTH'(9)) || c_q)) begin
                                acc_d = daa_sum[WIDTH-1:0];
                                c_d   = c_q | daa_sum[WIDTH];
                            end
                        end
                        4'hB: begin
                            acc_d = WIDTH'(c_q);
                            c_d   = 1'b0;
                        end
                        4'hC: begin
                            // A zero count degenerates to a single-cycle NOP.
                            if (bus.B != '0) begin
                                cnt_d   = bus.B;
                                state_d = ROT;
                                done_d  = 1'b0;
                            end
                        end
                        4'hD: begin
                            acc_d = '0;
                            c_d   = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            ROT: begin
                {c_d, acc_d} = {acc_q, c_q};
                cnt_d        = cnt_q - WIDTH'(1);
                if (cnt_q == WIDTH'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset wins over a rotate in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign bus.op_ready  = (state_q == IDLE);
    assign bus.carry_out = c_q;
    assign bus.acc_zero  = (acc_q == '0);
    assign bus.done      = done_q;

    assign data_bus = bus.ALU_enable ? acc_q : {WIDTH{1'bz}};
endmodule

// File: tb/tb_alu_acc_core.sv
// Bench for alu_acc_core: directed vector table, hand-written multi-cycle
// sequences and random ops against an arithmetic reference model.
module tb_alu_acc_core;
    logic       clk;
    logic       rst;
    wire  [3:0] data_bus;
    logic       tb_drv_en;
    logic [3:0] tb_drv_val;

    alu_acc_core_if #(.WIDTH(4)) bus_if ();

    alu_acc_core #(.WIDTH(4), .ENABLE_DAA(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus_if),
        .data_bus (data_bus)
    );

    // Second bus driver, used to show the core has released the bus.
    assign data_bus = tb_drv_en ? tb_drv_val : 4'bzzzz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks    = 0;
    int failures  = 0;
    int exp_dones = 0;
    int obs_dones = 0;
    int m_acc     = 0;
    int m_c       = 0;

    typedef struct {
        int op;
        int b;
        int acc;
        int c;
    } vec_t;

    vec_t vecs[$];

    always @(negedge clk) if (bus_if.done === 1'b1) obs_dones++;

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on a 4-bit accumulator and 1-bit carry.
    task automatic model_apply(input int op, input int b);
        int s;
        case (op)
            0: begin s = m_acc + b + m_c; m_acc = s % 16; m_c = s / 16; end
            1: begin s = m_acc - b - m_c; m_c = (s < 0) ? 1 : 0; m_acc = (s + 32) % 16; end
            2: m_acc = b;
            3: begin s = m_acc + 1; m_acc = s % 16; m_c = s / 16; end
            4: begin m_c = (m_acc == 0) ? 1 : 0; m_acc = (m_acc + 15) % 16; end
            5: m_c = 0;
            6: m_c = 1;
            7: m_c = 1 - m_c;
            8: begin s = m_acc * 2 + m_c; m_acc = s % 16; m_c = s / 16; end
            9: begin s = m_c * 16 + m_acc; m_c = s % 2; m_acc = s / 2; end
            10: if (m_acc > 9 || m_c == 1) begin
                    s = m_acc + 6; m_acc = s % 16; m_c = m_c | (s / 16);
                end
            11: begin m_acc = m_c; m_c = 0; end
            12: for (int k = 0; k < b; k++) begin
                    s = m_acc * 2 + m_c; m_acc = s % 16; m_c = s / 16;
                end
            13: begin m_acc = 0; m_c = 0; end
            default: ;
        endcase
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_acc"}, int'(data_bus), m_acc);
        chk({tag, "_carry"}, int'(bus_if.carry_out), m_c);
        chk({tag, "_zero"}, int'(bus_if.acc_zero), (m_acc == 0) ? 1 : 0);
    endtask

    // Issue one op at a negedge, wait for done, compare against the model.
    task automatic run_op(input int op, input int b);
        int n;
        int busy;
        int exp_busy;
        exp_busy = (op == 12) ? b : 0;
        bus_if.op_valid = 1'b1;
        bus_if.op_code  = op[3:0];
        bus_if.B        = b[3:0];
        @(negedge clk);
        bus_if.op_valid = 1'b0;
        n    = 0;
        busy = 0;
        while (bus_if.done !== 1'b1 && n < 40) begin
            if (bus_if.op_ready !== 1'b1) busy++;
            n++;
            @(negedge clk);
        end
        chk("done_seen", int'(bus_if.done), 1);
        chk("busy_cycles", busy, exp_busy);
        chk("done_latency", n, exp_busy);
        chk("ready_after", int'(bus_if.op_ready), 1);
        exp_dones++;
        model_apply(op, b);
        chk_state("op");
    endtask

    task automatic chk_release(input string tag);
        bus_if.ALU_enable = 1'b0;
        tb_drv_val = 4'(m_acc ^ 15);
        tb_drv_en  = 1'b1;
        #1;
        chk(tag, int'(data_bus), m_acc ^ 15);
        tb_drv_en  = 1'b0;
        bus_if.ALU_enable = 1'b1;
        #1;
    endtask

    task automatic add_vec(input int op, input int b, input int acc, input int c);
        vec_t v;
        v.op = op; v.b = b; v.acc = acc; v.c = c;
        vecs.push_back(v);
    endtask

    initial begin
        int n;
        int busy;

        rst = 1'b1;
        tb_drv_en = 1'b0;
        tb_drv_val = 4'h0;
        bus_if.op_valid = 1'b0;
        bus_if.op_code = 4'h0;
        bus_if.B = 4'h0;
        bus_if.ALU_enable = 1'b1;

        // Reset state with the bus enabled.
        @(negedge clk);
        @(negedge clk);
        chk("rst_bus", int'(data_bus), 0);
        chk("rst_carry", int'(bus_if.carry_out), 0);
        chk("rst_zero", int'(bus_if.acc_zero), 1);
        chk("rst_ready", int'(bus_if.op_ready), 1);
        chk("rst_done", int'(bus_if.done), 0);
        rst = 1'b0;
        @(negedge clk);

        // op, B, expected ACC, expected C
        add_vec(2, 15, 15, 0);  add_vec(0, 1, 0, 1);   add_vec(0, 1, 2, 0);
        add_vec(2, 3, 3, 0);    add_vec(5, 0, 3, 0);   add_vec(1, 5, 14, 1);
        add_vec(6, 0, 14, 1);   add_vec(1, 0, 13, 0);
        add_vec(2, 11, 11, 0);  add_vec(5, 0, 11, 0);  add_vec(10, 0, 1, 1);
        add_vec(2, 5, 5, 1);    add_vec(5, 0, 5, 0);   add_vec(10, 0, 5, 0);
        add_vec(2, 15, 15, 0);  add_vec(3, 0, 0, 1);   add_vec(4, 0, 15, 1);
        add_vec(4, 0, 14, 0);
        add_vec(2, 9, 9, 0);    add_vec(8, 0, 2, 1);   add_vec(9, 0, 9, 0);
        add_vec(6, 0, 9, 1);    add_vec(11, 0, 1, 0);  add_vec(7, 0, 1, 1);
        add_vec(2, 2, 2, 1);    add_vec(10, 0, 8, 1);
        add_vec(13, 0, 0, 0);   add_vec(14, 3, 0, 0);  add_vec(15, 5, 0, 0);
        add_vec(2, 6, 6, 0);    add_vec(12, 0, 6, 0);  add_vec(12, 3, 1, 1);

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].b);
            chk($sformatf("vec%0d_acc", i), int'(data_bus), vecs[i].acc);
            chk($sformatf("vec%0d_carry", i), int'(bus_if.carry_out), vecs[i].c);
        end

        // Rotate by 2 with a follow-up op held valid through the busy window.
        run_op(2, 9);
        run_op(5, 0);
        bus_if.op_valid = 1'b1;
        bus_if.op_code  = 4'hC;
        bus_if.B        = 4'h2;
        @(negedge clk);
        bus_if.op_code  = 4'h2;
        bus_if.B        = 4'h7;
        n = 0;
        busy = 0;
        while (bus_if.done !== 1'b1 && n < 40) begin
            if (bus_if.op_ready !== 1'b1) busy++;
            n++;
            @(negedge clk);
        end
        chk("hold_busy", busy, 2);
        chk("hold_rol_done", int'(bus_if.done), 1);
        chk("hold_rol_acc", int'(data_bus), 5);
        chk("hold_rol_carry", int'(bus_if.carry_out), 0);
        exp_dones++;
        model_apply(12, 2);
        @(negedge clk);
        bus_if.op_valid = 1'b0;
        chk("hold_ld_done", int'(bus_if.done), 1);
        chk("hold_ld_acc", int'(data_bus), 7);
        exp_dones++;
        model_apply(2, 7);
        @(negedge clk);
        chk("hold_done_low", int'(bus_if.done), 0);
        chk_release("release_bus_7");

        // Reset in the middle of a rotate-by-4.
        run_op(2, 10);
        run_op(5, 0);
        bus_if.op_valid = 1'b1;
        bus_if.op_code  = 4'hC;
        bus_if.B        = 4'h4;
        @(negedge clk);
        bus_if.op_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy", int'(bus_if.op_ready), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_acc", int'(data_bus), 0);
        chk("abort_carry", int'(bus_if.carry_out), 0);
        chk("abort_ready", int'(bus_if.op_ready), 1);
        chk("abort_done", int'(bus_if.done), 0);
        rst = 1'b0;
        m_acc = 0;
        m_c = 0;
        @(negedge clk);
        chk("abort_done_after", int'(bus_if.done), 0);
        chk("abort_ready_after", int'(bus_if.op_ready), 1);

        // Random ops against the model.
        for (int i = 0; i < 250; i++) begin
            run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            if (i % 25 == 0) chk_release("release_bus_rand");
        end

        @(negedge clk);
        @(negedge clk);
        chk("done_pulse_count", obs_dones, exp_dones);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
